ds_cic_decimator: RTL and testbench
===================================

DS_CIC_DECIMATOR -- requirements
Module: ds_cic_decimator

Interface
REQ-001 Parameter DEC_LOG2, default 6: log2 of decimation ratio R (R = 2^DEC_LOG2, legal 2..8).
REQ-002 Parameter OUT_W, default 16: output word width, two's complement.
REQ-003 CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; assertion clears all state immediately, release synchronous to CLK.
REQ-005 din  input  1  modulator bitstream bit: 1 maps to +1, 0 maps to -1.
REQ-006 din_valid  input  1  din sampled only on cycles where din_valid=1.
REQ-007 dout  output  OUT_W  decimated PCM sample, signed.
REQ-008 dout_valid  output  1  dout holds an unconsumed sample.
REQ-009 dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1.
REQ-010 overrun  output  1  sticky lost-sample flag; present only with DS_DEC_OVERRUN_EN.

Function
REQ-011 Third-order CIC (sinc3): three cascaded integrators at input rate, decimate by R, three cascaded differentiators (comb, delay 1) at output rate.
REQ-012 Internal width ACC_W = 2 + 3*DEC_LOG2 bits; integrators wrap modulo 2^ACC_W; wrap is intended and SHALL yield exact comb results.
REQ-013 Integrators advance only on din_valid=1 cycles; din_valid=0 cycles freeze all integrator and counter state.
REQ-014 Decimation counter counts accepted samples 0..R-1, wraps to 0; strobe on the accepted sample with count R-1.
REQ-015 Comb stages evaluate once per strobe; result registered; dout_valid rises exactly 1 cycle after the strobe cycle.
REQ-016 Comb full-scale ±2^(3*DEC_LOG2); output = comb result arithmetic-shifted right by 3*DEC_LOG2-(OUT_W-1) (left if negative), then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; +full-scale SHALL give 32767 (OUT_W=16).
REQ-017 dout stable while dout_valid=1 and dout_ready=0.
REQ-018 dout_valid clears the cycle after a handshake unless a new result loads that same cycle, in which case dout_valid stays 1 with the new value.
REQ-019 New result while an unconsumed sample is held: new result overwrites dout; old sample is lost.
REQ-020 First three output samples after reset are transient (comb history zero); sample 4 onward is settled.

Reset
REQ-021 While reset=0: integrators, comb delays, counter, dout=0, dout_valid=0, overrun=0.
REQ-022 Reset asserted mid-frame discards partial frame; after release counting restarts at 0 and next strobe needs R fresh accepted samples.

Configuration
REQ-023 Macro DS_DEC_OVERRUN_EN defined: overrun port exists; set on any REQ-019 overwrite, held until reset.
REQ-024 DS_DEC_OVERRUN_EN undefined: no overrun port, no flag logic; overwrite behaviour per REQ-019 unchanged.

Structure
REQ-025 Shared package ds_pkg holds DEC_LOG2 default, OUT_W default, ACC_W derivation function, and saturation-limit constants.
REQ-026 One sub-module ds_cic_comb: single differentiator stage (register + subtract, enable on strobe), instantiated three times.

Verification
REQ-027 din=1 every cycle, din_valid=1, dout_ready=1 -> from 4th output onward dout=32767 each sample; dout_valid pulses once per 64 cycles, 1 cycle after each strobe.
REQ-028 din=0 constant -> settled dout=-32768; din alternating 1,0 -> settled dout=0.
REQ-029 din_valid=1 every other cycle, din=1 -> output interval 128 cycles, settled value 32767, identical to REQ-027 sequence.
REQ-030 dout_ready=0 across two strobes -> dout shows second sample, dout_valid stays 1; with DS_DEC_OVERRUN_EN overrun=1 until reset.
REQ-031 reset pulsed low at accepted sample 30 of a frame -> all outputs 0 within the same cycle (asynchronous); first dout_valid exactly 64 accepted samples + 1 cycle after release.

Source files
------------

// File: rtl/ds_pkg.sv
// ds_pkg -- shared definitions for the sigma-delta sinc3 decimator.
//
// Holds the default decimation and output-width parameters, the derivation
// of the internal accumulator width, and the output saturation limits.
// No ports; imported with `import ds_pkg::*;`.
package ds_pkg;

  // Default log2 of the decimation ratio (R = 64).
  localparam int DEC_LOG2_DEF = 6;

  // Default output word width (two's complement).
  localparam int OUT_W_DEF = 16;

  // Bits needed to hold the sinc3 gain R^3 = 2^(3*DEC_LOG2) as a signed value,
  // including +full-scale itself. Integrators wrap at this width and the comb
  // differences still come out exact.
  function automatic int acc_w(input int dec_log2);
    return 2 + 3 * dec_log2;
  endfunction

  // Largest and smallest representable output codes for a given width.
  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Saturation limits at the default output width.
  localparam longint SAT_HI_DEF = (longint'(1) <<< (OUT_W_DEF - 1)) - 1;
  localparam longint SAT_LO_DEF = -(longint'(1) <<< (OUT_W_DEF - 1));

endpackage : ds_pkg

// File: rtl/ds_cic_decimator_if.sv
// ds_cic_decimator_if -- bitstream input and PCM output stream bundle.
//
// Signals:
//   din         modulator bit (1 -> +1, 0 -> -1)
//   din_valid   din is sampled on cycles where this is 1
//   dout        decimated signed PCM sample, OUT_W bits
//   dout_valid  dout holds an unconsumed sample
//   dout_ready  consumer accepts dout when dout_valid is also 1
// Modports:
//   master  the environment: drives the bitstream, consumes PCM
//   slave   the decimator
interface ds_cic_decimator_if
  import ds_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
);
  logic                    din;
  logic                    din_valid;
  logic signed [OUT_W-1:0] dout;
  logic                    dout_valid;
  logic                    dout_ready;

  modport master (
    output din,
    output din_valid,
    output dout_ready,
    input  dout,
    input  dout_valid
  );

  modport slave (
    input  din,
    input  din_valid,
    input  dout_ready,
    output dout,
    output dout_valid
  );
endinterface : ds_cic_decimator_if

// File: rtl/ds_cic_comb.sv
// ds_cic_comb -- one differentiator (comb, delay 1) stage of a CIC decimator.
//
// Ports:
//   CLK    clock
//   reset  asynchronous active-low reset, clears the delay register
//   en     decimation strobe; the delay register captures x only when set
//   x      stage input (wrapping two's complement, W bits)
//   y      x minus the value captured at the previous strobe (combinational)
module ds_cic_comb
  import ds_pkg::*;
#(
  parameter int W = acc_w(DEC_LOG2_DEF)
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                en,
  input  logic signed [W-1:0] x,
  output logic signed [W-1:0] y
);

  logic signed [W-1:0] dly_reg;

  // Modular subtraction: undoes the integrator wrap exactly.
  assign y = x - dly_reg;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      dly_reg <= '0;
    end else if (en) begin
      dly_reg <= x;
    end
  end

endmodule : ds_cic_comb

// File: rtl/ds_cic_decimator.sv
// ds_cic_decimator -- third-order CIC (sinc3) decimator for a 1-bit
// sigma-delta bitstream, ratio R = 2^DEC_LOG2, with a valid/ready output.
//
// Three integrators run at the accepted-input rate; on the R-th accepted
// sample the three comb stages evaluate and the scaled, saturated result is
// registered into dout, so dout_valid rises one cycle after that sample.
// A new result overwrites a sample that is still held unconsumed.
//
// Ports:
//   CLK      clock, all state changes on the rising edge
//   reset    asynchronous active-low reset
//   bus      ds_cic_decimator_if.slave (din, din_valid, dout, dout_valid,
//            dout_ready)
//   overrun  sticky lost-sample flag, only when DS_DEC_OVERRUN_EN is defined
//
// Build option: define DS_DEC_OVERRUN_EN to add the overrun port and flag.
module ds_cic_decimator
  import ds_pkg::*;
#(
  parameter int DEC_LOG2 = DEC_LOG2_DEF,
  parameter int OUT_W    = OUT_W_DEF
) (
  input  logic                     CLK,
  input  logic                     reset,
  ds_cic_decimator_if.slave        bus
`ifdef DS_DEC_OVERRUN_EN
  ,
  output logic                     overrun
`endif
);

  localparam int ACC_W = acc_w(DEC_LOG2);
  // Right shift mapping comb full-scale 2^(3*DEC_LOG2) onto 2^(OUT_W-1);
  // negative means the output word is wider than the comb and we shift left.
  localparam int SH = 3 * DEC_LOG2 - (OUT_W - 1);
  // Wide enough for either shift direction without losing the sign.
  localparam int WIDE_W = ACC_W + OUT_W + 1;
  localparam logic signed [WIDE_W-1:0] LIM_HI = WIDE_W'(sat_hi(OUT_W));
  localparam logic signed [WIDE_W-1:0] LIM_LO = WIDE_W'(sat_lo(OUT_W));

  // ---------------------------------------------------------------------
  // Input mapping and decimation counter
  // ---------------------------------------------------------------------
  logic signed [ACC_W-1:0] x_ext;
  logic [DEC_LOG2-1:0]     cnt_reg;
  logic                    strobe;

  assign x_ext  = bus.din ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};
  // The counter is a power-of-two wide, so R-1 is all ones and it wraps by itself.
  assign strobe = bus.din_valid && (&cnt_reg);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (bus.din_valid) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Integrators. Each stage's next value feeds the following stage in the
  // same cycle, so on the strobe cycle the last stage's next value already
  // includes the R-th sample and the combs can use it directly.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_integ
      logic signed [ACC_W-1:0] acc_reg;
      logic signed [ACC_W-1:0] acc_next;
      logic signed [ACC_W-1:0] addend;

      if (gi == 0) begin : g_src
        assign addend = x_ext;
      end else begin : g_src
        assign addend = g_integ[gi-1].acc_next;
      end

      assign acc_next = acc_reg + addend;

      always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
          acc_reg <= '0;
        end else if (bus.din_valid) begin
          acc_reg <= acc_next;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Comb chain, evaluated on the strobe
  // ---------------------------------------------------------------------
  generate
    for (gi = 0; gi < 3; gi++) begin : g_comb
      logic signed [ACC_W-1:0] c_in;
      logic signed [ACC_W-1:0] c_out;

      if (gi == 0) begin : g_src
        assign c_in = g_integ[2].acc_next;
      end else begin : g_src
        assign c_in = g_comb[gi-1].c_out;
      end

      ds_cic_comb #(
        .W (ACC_W)
      ) u_comb (
        .CLK   (CLK),
        .reset (reset),
        .en    (strobe),
        .x     (c_in),
        .y     (c_out)
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Scaling and saturation
  // ---------------------------------------------------------------------
  logic signed [WIDE_W-1:0] wide_ext;
  logic signed [WIDE_W-1:0] wide_scaled;
  logic signed [OUT_W-1:0]  sat_val;

  assign wide_ext = {{(WIDE_W-ACC_W){g_comb[2].c_out[ACC_W-1]}}, g_comb[2].c_out};

  generate
    if (SH >= 0) begin : g_shr
      assign wide_scaled = wide_ext >>> SH;
    end else begin : g_shl
      assign wide_scaled = wide_ext <<< (-SH);
    end
  endgenerate

  // +full-scale lands one code above the positive limit and is clipped here.
  always_comb begin
    sat_val = wide_scaled[OUT_W-1:0];
    if (wide_scaled > LIM_HI) begin
      sat_val = LIM_HI[OUT_W-1:0];
    end else if (wide_scaled < LIM_LO) begin
      sat_val = LIM_LO[OUT_W-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // Output register and handshake
  // ---------------------------------------------------------------------
  logic signed [OUT_W-1:0] dout_reg;
  logic                    dout_valid_reg;

  // A fresh result always loads, even over an unconsumed one; a handshake in
  // the same cycle as a load leaves valid set for the new value.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
    end else if (strobe) begin
      dout_reg       <= sat_val;
      dout_valid_reg <= 1'b1;
    end else if (dout_valid_reg && bus.dout_ready) begin
      dout_valid_reg <= 1'b0;
    end
  end

  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid_reg;

`ifdef DS_DEC_OVERRUN_EN
  logic overrun_reg;
  logic sample_lost;

  // The held sample is lost only if it is not being taken in the load cycle.
  assign sample_lost = strobe && dout_valid_reg && !bus.dout_ready;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      overrun_reg <= 1'b0;
    end else if (sample_lost) begin
      overrun_reg <= 1'b1;
    end
  end

  assign overrun = overrun_reg;
`endif

endmodule : ds_cic_decimator

// File: tb/tb_ds_cic_decimator.sv
// tb_ds_cic_decimator -- scoreboard bench for ds_cic_decimator.
//
// The reference model treats the decimator as a zero-state linear filter:
// every R-th accepted bit it convolves the full accepted-bit history with
// the sinc3 impulse response (three length-R boxcars), scales and clips.
// Expected samples go into a queue; a monitor pops one per handshake.
module tb_ds_cic_decimator;

  localparam int DEC_LOG2 = 6;
  localparam int OUT_W    = 16;
  localparam int R        = 1 << DEC_LOG2;
  localparam int HLEN     = 3 * R - 2;
  localparam int SHIFT    = 3 * DEC_LOG2 - (OUT_W - 1);
  localparam longint OMAX = 32767;
  localparam longint OMIN = -32768;

  typedef struct {
    int val;
    int due;
    bit chk_time;
  } exp_t;

  logic clk;
  logic reset;
`ifdef DS_DEC_OVERRUN_EN
  logic overrun;
`endif

  ds_cic_decimator_if #(.OUT_W(OUT_W)) bus ();

  ds_cic_decimator #(
    .DEC_LOG2 (DEC_LOG2),
    .OUT_W    (OUT_W)
  ) dut (
    .CLK     (clk),
    .reset   (reset),
    .bus     (bus)
`ifdef DS_DEC_OVERRUN_EN
    ,
    .overrun (overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   h [HLEN];
  bit   hist [$];
  int   acc_cnt  = 0;
  exp_t exp_q [$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Zero-state sinc3 response to everything accepted since reset.
  function automatic int model_out();
    longint y = 0;
    int n = hist.size() - 1;
    for (int k = 0; k < HLEN && k <= n; k++)
      y += longint'(h[k]) * (hist[n-k] ? 1 : -1);
    y = y >>> SHIFT;
    if (y > OMAX) y = OMAX;
    if (y < OMIN) y = OMIN;
    return int'(y);
  endfunction

  // One input cycle. Called at posedge+1; returns at the next posedge+1.
  task automatic step(input bit d, input bit v);
    exp_t e;
    bus.din       = d;
    bus.din_valid = v;
    if (v) begin
      hist.push_back(d);
      acc_cnt++;
      if (acc_cnt % R == 0) begin
        // An unconsumed sample still waiting while the consumer stalls is overwritten.
        if (!bus.dout_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        e.val      = model_out();
        e.due      = cyc + 1;
        e.chk_time = bus.dout_ready;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: one comparison per handshake.
  always @(negedge clk) begin
    if (reset && bus.dout_valid && bus.dout_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("dout", bus.dout, e.val);
        $display("sample: dout=%0d expected=%0d cycle=%0d", bus.dout, e.val, cyc);
        if (e.chk_time) check("latency", cyc, e.due);
      end
    end
  end

  initial begin
    int first_val;

    for (int k = 0; k < HLEN; k++) h[k] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++)
          h[a+b+c]++;

    bus.din        = 1'b0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    reset          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", bus.dout, 0);
    check("reset_valid", bus.dout_valid, 0);
`ifdef DS_DEC_OVERRUN_EN
    check("reset_overrun", overrun, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Constant +1, constant -1, alternating.
    for (int i = 0; i < 6 * R; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 6 * R; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 6 * R; i++) step(i[0] ? 1'b0 : 1'b1, 1'b1);
    // din_valid every other cycle; din during idle cycles must be ignored.
    for (int i = 0; i < 6 * R; i++) begin
      step(1'b1, 1'b1);
      step(1'($urandom_range(0, 1)), 1'b0);
    end
    // Random bits with random gaps.
    for (int i = 0; i < 10 * R; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));

    // Stalled consumer across two strobes.
    while (acc_cnt % R != 0) step(1'b1, 1'b1);
    bus.dout_ready = 1'b0;
    for (int i = 0; i < R; i++) step(1'($urandom_range(0, 1)), 1'b1);
    first_val = exp_q[0].val;
    check("stall_first_dout", bus.dout, first_val);
    check("stall_first_valid", bus.dout_valid, 1);
    for (int i = 0; i < R - 1; i++) step(1'($urandom_range(0, 1)), 1'b1);
    check("stall_hold_dout", bus.dout, first_val);
    check("stall_hold_valid", bus.dout_valid, 1);
    step(1'b1, 1'b1);
    check("overwrite_dout", bus.dout, exp_q[0].val);
    check("overwrite_valid", bus.dout_valid, 1);
    check("overwrite_queue", exp_q.size(), 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
`ifdef DS_DEC_OVERRUN_EN
    check("overrun_set", overrun, 1);
`endif
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    check("stall_drained", exp_q.size(), 0);

    // Reset in the middle of a frame.
    for (int i = 0; i < 3 * R; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_dout", bus.dout, 0);
    check("midreset_valid", bus.dout_valid, 0);
`ifdef DS_DEC_OVERRUN_EN
    check("midreset_overrun", overrun, 0);
`endif
    hist.delete();
    exp_q.delete();
    acc_cnt = 0;
    bus.din_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < R - 1; i++) step(1'b1, 1'b1);
    check("post_reset_no_early", bus.dout_valid, 0);
    step(1'b1, 1'b1);
    check("post_reset_first_valid", bus.dout_valid, 1);
    for (int i = 0; i < 3 * R; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 8));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ds_cic_decimator
